// File: rtl/dcm_lock_watchdog_if.sv
// dcm_lock_watchdog_if: DCM supervision signals between the watchdog and its surroundings
interface dcm_lock_watchdog_if #(
  parameter int MAX_RETRY = 3
);
  logic LOCKED;
  logic HEARTBEAT;
  logic CLEAR_FAULT;
  logic DCM_RST;
  logic CLK_OK;
  logic FAULT;
  logic [$clog2(MAX_RETRY+1)-1:0] RETRY_CNT;
  modport master (
    output LOCKED, HEARTBEAT, CLEAR_FAULT,
    input  DCM_RST, CLK_OK, FAULT, RETRY_CNT
  );
  modport slave (
    input  LOCKED, HEARTBEAT, CLEAR_FAULT,
    output DCM_RST, CLK_OK, FAULT, RETRY_CNT
  );
endinterface

// File: rtl/dcm_lock_watchdog.sv
// dcm_lock_watchdog: pulses the DCM reset, waits for lock, watches the WB heartbeat and retries up to MAX_RETRY before latching FAULT
module dcm_lock_watchdog #(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_PULSE    = 128,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int HB_TIMEOUT   = 256,
  parameter int MAX_RETRY    = 3
) (
  input logic CLK,
  input logic RESET,
  dcm_lock_watchdog_if.slave bus
);
  localparam int TW = $clog2((LOCK_TIMEOUT > RST_PULSE ? LOCK_TIMEOUT : RST_PULSE) + 1);
  localparam int HW = $clog2(HB_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN, S_FAULT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] lock_sr;
  logic [SYNC_STAGES-1:0] hb_sr;
  logic hb_prev;
  logic lock_s;
  logic hb_edge;
  logic fail;
  logic last;
  logic [TW-1:0] timer;
  logic [HW-1:0] hb_timer;
  logic [RW-1:0] retry_cnt;
  logic dcm_rst;
  logic clk_ok;
  logic fault;
  assign lock_s  = lock_sr[SYNC_STAGES-1];
  assign hb_edge = hb_sr[SYNC_STAGES-1] ^ hb_prev;
  assign last    = retry_cnt == RW'(MAX_RETRY);
  assign bus.DCM_RST   = dcm_rst;
  assign bus.CLK_OK    = clk_ok;
  assign bus.FAULT     = fault;
  assign bus.RETRY_CNT = retry_cnt;
  // A retry is due on a lock timeout while waiting, or on lost lock / stalled heartbeat while running
  always_comb begin
    fail = (state == S_WAIT && !lock_s && timer == TW'(LOCK_TIMEOUT-1)) ||
           (state == S_RUN && (!lock_s || hb_timer == HW'(HB_TIMEOUT-1)));
  end
  // Bring LOCKED and HEARTBEAT into the CLK domain; hb_prev delays the heartbeat once for edge detection
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      lock_sr <= '0;
      hb_sr   <= '0;
      hb_prev <= 1'b0;
    end else begin
      lock_sr <= {lock_sr[SYNC_STAGES-2:0], bus.LOCKED};
      hb_sr   <= {hb_sr[SYNC_STAGES-2:0], bus.HEARTBEAT};
      hb_prev <= hb_sr[SYNC_STAGES-1];
    end
  // Supervisor FSM; outputs are registered together with the state they belong to
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state     <= S_RST;
      timer     <= '0;
      hb_timer  <= '0;
      retry_cnt <= '0;
      dcm_rst   <= 1'b1;
      clk_ok    <= 1'b0;
      fault     <= 1'b0;
    end else if (fail) begin
      state     <= last ? S_FAULT : S_RST;
      retry_cnt <= last ? retry_cnt : retry_cnt + RW'(1);
      timer     <= '0;
      dcm_rst   <= 1'b1;
      clk_ok    <= 1'b0;
      fault     <= last;
    end else begin
      case (state)
        S_RST:
          if (timer == TW'(RST_PULSE-1)) begin
            state   <= S_WAIT;
            timer   <= '0;
            dcm_rst <= 1'b0;
          end else timer <= timer + TW'(1);
        S_WAIT:
          if (lock_s) begin
            state    <= S_RUN;
            timer    <= '0;
            hb_timer <= '0;
            clk_ok   <= 1'b1;
          end else timer <= timer + TW'(1);
        S_RUN: begin
          hb_timer <= hb_edge ? '0 : hb_timer + HW'(1);
          if (timer != TW'(LOCK_TIMEOUT-1)) timer <= timer + TW'(1);
          if (timer == TW'(LOCK_TIMEOUT-2)) retry_cnt <= '0;
        end
        default:
          if (bus.CLEAR_FAULT) begin
            state     <= S_RST;
            timer     <= '0;
            retry_cnt <= '0;
            fault     <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_dcm_lock_watchdog.sv
// tb_dcm_lock_watchdog: directed scenarios plus random lock/heartbeat traffic against a behavioural model
module tb_dcm_lock_watchdog;
  localparam int S  = 2;
  localparam int RP = 128;
  localparam int LT = 4096;
  localparam int HB = 256;
  localparam int MR = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dcm_lock_watchdog_if #(.MAX_RETRY(MR)) bus();
  dcm_lock_watchdog #(
    .SYNC_STAGES(S), .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .HB_TIMEOUT(HB), .MAX_RETRY(MR)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  // model: phase 0 pulse, 1 wait, 2 run, 3 fault
  int ph, cnt, age, retries;
  bit lq[$];
  bit hq[$];
  bit hb_on = 1'b1;
  int hb_per = 16;
  int hb_ctr = 0;
  int since_tog = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask
  function automatic logic [4:0] outs();
    return {bus.DCM_RST, bus.CLK_OK, bus.FAULT, bus.RETRY_CNT};
  endfunction
  function automatic logic [4:0] model_outs();
    return {ph == 0 || ph == 3, ph == 2, ph == 3, 2'(retries)};
  endfunction
  function automatic void model_reset();
    ph = 0; cnt = 0; age = 0; retries = 0;
    lq = {}; hq = {};
    for (int i = 0; i <= S; i++) begin
      lq.push_back(1'b0);
      hq.push_back(1'b0);
    end
  endfunction
  function automatic void retry();
    if (retries == MR) ph = 3;
    else begin
      retries++;
      ph = 0;
      cnt = 0;
    end
  endfunction
  function automatic void model_step();
    bit ls, he;
    if (rst) begin
      model_reset();
      return;
    end
    ls = lq[S-1];
    he = hq[S-1] ^ hq[S];
    case (ph)
      0: begin
        cnt++;
        if (cnt == RP) begin ph = 1; cnt = 0; end
      end
      1: begin
        if (ls) begin ph = 2; cnt = 0; age = 0; end
        else begin
          cnt++;
          if (cnt == LT) retry();
        end
      end
      2: begin
        if (!ls || age == HB-1) retry();
        else begin
          age = he ? 0 : age + 1;
          cnt++;
          if (cnt == LT-1) retries = 0;
        end
      end
      default: if (bus.CLEAR_FAULT) begin retries = 0; ph = 0; cnt = 0; end
    endcase
    lq.push_front(bus.LOCKED); void'(lq.pop_back());
    hq.push_front(bus.HEARTBEAT); void'(hq.pop_back());
  endfunction
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs", outs(), model_outs());
    since_tog++;
    hb_ctr++;
    if (hb_on && hb_ctr >= hb_per) begin
      hb_ctr = 0;
      bus.HEARTBEAT = ~bus.HEARTBEAT;
      since_tog = 0;
    end
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("async_rst", outs(), 5'b10000);
    model_reset();
    tick();
    rst = 1'b0;
  endtask
  task automatic dropout(output int lat);
    int n, m;
    bus.LOCKED = 1'b0;
    n = 0;
    while (bus.CLK_OK && n < 20) begin tick(); n++; end
    lat = n;
    repeat (5 - n) tick();
    bus.LOCKED = 1'b1;
    m = 0;
    while (!bus.CLK_OK && m < 500) begin tick(); m++; end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, lat;
    bus.LOCKED = 1'b0;
    bus.HEARTBEAT = 1'b0;
    bus.CLEAR_FAULT = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_outs", outs(), 5'b10000);
    rst = 1'b0;
    n = 0;
    while (bus.DCM_RST && n < 1000) begin tick(); n++; end
    check("pulse_len", n, RP);
    repeat (200 - RP) tick();
    bus.LOCKED = 1'b1;
    n = 0;
    while (!bus.CLK_OK && n < 100) begin tick(); n++; end
    check("lock_latency", n, S + 1);
    check("retry_idle", bus.RETRY_CNT, 0);
    repeat (100) tick();
    hb_on = 1'b0;
    n = 0;
    while (bus.CLK_OK && n < 1000) begin tick(); n++; end
    check("hb_stall", since_tog, HB + S + 1);
    n = 0;
    while (bus.DCM_RST && n < 1000) begin tick(); n++; end
    check("retry_pulse", n, RP);
    check("retry_one", bus.RETRY_CNT, 1);
    hb_on = 1'b1;
    n = 0;
    while (!bus.CLK_OK && n < 100) begin tick(); n++; end
    check("relock", bus.CLK_OK, 1);
    dropout(lat);
    check("drop_lat", lat, S + 1);
    check("retry_two", bus.RETRY_CNT, 2);
    repeat (LT + 50) tick();
    check("stable_clear", bus.RETRY_CNT, 0);
    dropout(lat);
    check("drop_lat2", lat, S + 1);
    check("retry_after_stable", bus.RETRY_CNT, 1);
    async_reset();
    repeat (50) tick();
    bus.LOCKED = 1'b0;
    hb_on = 1'b0;
    async_reset();
    n = 0;
    while (!bus.FAULT && n < 20000) begin tick(); n++; end
    check("fault_time", n, 4 * (RP + LT));
    check("fault_retry", bus.RETRY_CNT, MR);
    check("fault_dcm_rst", bus.DCM_RST, 1);
    for (int i = 0; i < 200; i++) begin
      bus.LOCKED = 1'($urandom_range(0, 1));
      bus.HEARTBEAT = 1'($urandom_range(0, 1));
      tick();
    end
    check("fault_held", bus.FAULT, 1);
    bus.LOCKED = 1'b1;
    bus.CLEAR_FAULT = 1'b1;
    tick();
    bus.CLEAR_FAULT = 1'b0;
    check("clear_fault", bus.FAULT, 0);
    check("clear_retry", bus.RETRY_CNT, 0);
    hb_on = 1'b1;
    n = 0;
    while (bus.DCM_RST && n < 1000) begin tick(); n++; end
    check("clear_pulse", n, RP);
    n = 0;
    while (!bus.CLK_OK && n < 100) begin tick(); n++; end
    check("clear_relock", bus.CLK_OK, 1);
    for (int i = 0; i < 20000; i++) begin
      if (i % 1000 == 0) hb_per = $urandom_range(4, 320);
      if (bus.LOCKED) begin
        if ($urandom_range(0, 799) == 0) bus.LOCKED = 1'b0;
      end else if ($urandom_range(0, 99) == 0) bus.LOCKED = 1'b1;
      bus.CLEAR_FAULT = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.CLEAR_FAULT = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
